// File: rtl/mm_sched.sv
// mm_sched: command FIFO feeding a matrix-multiply job FSM with tile counting and response handshake.
// Optional watchdog abort enabled by defining MM_SCHED_TIMEOUT_EN.
`ifndef AD
`define AD 3
`endif
module mm_sched #(
    parameter int DEPTH   = 4,
    parameter int ID_W    = 4,
    parameter int TILE_W  = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [1:0]               i_cmd_mode,
    input  logic [ID_W-1:0]          i_cmd_id,
    output logic [1:0]               o_mm_mode,
    output logic                     o_mm_start,
    input  logic                     i_mm_tile_done,
    input  logic                     i_mm_mtrx_done,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [ID_W-1:0]          o_rsp_id,
    output logic [TILE_W-1:0]        o_rsp_tiles,
    output logic                     o_rsp_err,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_fifo_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [7:0] AD_LAST = 8'(`AD - 1);

    typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, RESP} state_t;
    state_t state, state_nx;

    logic [ID_W+1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   cnt;
    logic            push, pop, wd_fire;
    logic [1:0]      job_mode;
    logic [ID_W-1:0] job_id;
    logic [TILE_W-1:0] tiles;
    logic [7:0]      drain_cnt;

    assign o_cmd_ready = cnt < FULL;
    assign push        = i_cmd_valid && o_cmd_ready;
    assign o_mm_mode   = job_mode;
    assign o_rsp_id    = job_id;
    assign o_rsp_tiles = tiles;
    assign o_fifo_cnt  = cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        pop         = 1'b0;
        o_mm_start  = 1'b0;
        o_rsp_valid = 1'b0;
        o_busy      = state != IDLE;
        case (state)
            IDLE: begin
                pop      = cnt != '0;
                state_nx = pop ? START : IDLE;
            end
            START: begin
                o_mm_start = 1'b1;
                state_nx   = RUN;
            end
            RUN:   state_nx = i_mm_mtrx_done ? DRAIN : (wd_fire ? RESP : RUN);
            DRAIN: state_nx = drain_cnt == AD_LAST ? RESP : DRAIN;
            RESP: begin
                o_rsp_valid = 1'b1;
                state_nx    = i_rsp_ready ? IDLE : RESP;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= {i_cmd_mode, i_cmd_id};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            job_mode  <= '0;
            job_id    <= '0;
            tiles     <= '0;
            drain_cnt <= '0;
        end else begin
            wr_ptr    <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr    <= pop ? rd_ptr + 1'b1 : rd_ptr;
            cnt       <= cnt + CW'(push) - CW'(pop);
            drain_cnt <= state == DRAIN ? drain_cnt + 8'd1 : 8'd0;
            if (pop) begin
                {job_mode, job_id} <= mem[rd_ptr];
                tiles              <= '0;
            end else if (state == RUN && i_mm_tile_done && !(&tiles)) begin
                tiles <= tiles + 1'b1;
            end
        end
    end

`ifdef MM_SCHED_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
    logic [WW-1:0] wd;
    logic          err;
    // wd counts quiet RUN cycles; it is zero on RUN entry because it clears outside RUN
    assign wd_fire   = state == RUN && !i_mm_tile_done && !i_mm_mtrx_done && wd == WD_LAST;
    assign o_rsp_err = err;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wd  <= '0;
            err <= 1'b0;
        end else begin
            wd  <= (state == RUN && !i_mm_tile_done) ? wd + 1'b1 : '0;
            err <= pop ? 1'b0 : (wd_fire ? 1'b1 : err);
        end
    end
`else
    assign wd_fire   = 1'b0;
    assign o_rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_mm_sched.sv
// tb_mm_sched: directed vector table, hand-written corner sequences and a randomized run
// against a transaction-level reference model of mm_sched.
`ifndef AD
`define AD 3
`endif
`ifndef INT8
`define INT8 2'd1
`endif
`ifndef INT4
`define INT4 2'd2
`endif
`ifndef INT4_VSQ
`define INT4_VSQ 2'd3
`endif
module tb_mm_sched;
    localparam int DEPTH = 4;
    localparam int TO = 16;
`ifdef MM_SCHED_TIMEOUT_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic        i_clk = 1'b0, i_rst = 1'b0;
    logic        i_cmd_valid = 1'b0, o_cmd_ready;
    logic [1:0]  i_cmd_mode = '0, o_mm_mode;
    logic [3:0]  i_cmd_id = '0, o_rsp_id;
    logic        o_mm_start, i_mm_tile_done = 1'b0, i_mm_mtrx_done = 1'b0;
    logic        o_rsp_valid, i_rsp_ready = 1'b0, o_rsp_err, o_busy;
    logic [15:0] o_rsp_tiles;
    logic [2:0]  o_fifo_cnt;

    mm_sched #(.DEPTH(DEPTH), .ID_W(4), .TILE_W(16), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_mode(i_cmd_mode), .i_cmd_id(i_cmd_id), .o_mm_mode(o_mm_mode), .o_mm_start(o_mm_start),
        .i_mm_tile_done(i_mm_tile_done), .i_mm_mtrx_done(i_mm_mtrx_done), .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(i_rsp_ready), .o_rsp_id(o_rsp_id), .o_rsp_tiles(o_rsp_tiles), .o_rsp_err(o_rsp_err),
        .o_busy(o_busy), .o_fifo_cnt(o_fifo_cnt)
    );

    always #5 i_clk = ~i_clk;

    int total = 0, passed = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic quiet_inputs();
        i_cmd_valid = 0; i_mm_tile_done = 0; i_mm_mtrx_done = 0; i_rsp_ready = 0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        i_rst = 1;
        tick();
        i_rst = 0;
    endtask

    function automatic logic [8:0] ctl();
        return {o_cmd_ready, o_mm_start, o_mm_mode, o_rsp_valid, o_busy, o_fifo_cnt};
    endfunction

    function automatic logic [8:0] o(input logic rdy, input logic st, input logic [1:0] md,
                                     input logic rv, input logic bz, input logic [2:0] c);
        return {rdy, st, md, rv, bz, c};
    endfunction

    typedef struct {
        logic       vld;
        logic [1:0] mode;
        logic [3:0] id;
        logic       tile, mtrx, rdy;
        logic [8:0] exp_o;
        logic [3:0] exp_id;
        logic [15:0] exp_tiles;
    } vec_t;

    function automatic vec_t v(input logic vld, input logic [3:0] id, input logic tile, input logic mtrx,
                               input logic rdy, input logic [8:0] e, input logic [15:0] et);
        vec_t r;
        r.vld = vld; r.mode = `INT8; r.id = id; r.tile = tile; r.mtrx = mtrx; r.rdy = rdy;
        r.exp_o = e; r.exp_id = 4'd3; r.exp_tiles = et;
        return r;
    endfunction

    vec_t tbl [14];

    initial begin
        logic [5:0] q [$];
        logic [5:0] cur;
        logic [15:0] mt;
        logic me, push;
        int ph, dl, quiet, n;

        // one INT8 job (id 3): 5 tiles, 5th coincides with matrix done, then drain and response
        tbl[0]  = v(1, 3, 0, 0, 0, o(1, 0, 2'd0,  0, 0, 0), 0);
        tbl[1]  = v(0, 0, 0, 0, 0, o(1, 0, 2'd0,  0, 0, 1), 0);
        tbl[2]  = v(0, 0, 0, 0, 0, o(1, 1, `INT8, 0, 1, 0), 0);
        tbl[3]  = v(0, 0, 1, 0, 0, o(1, 0, `INT8, 0, 1, 0), 0);
        tbl[4]  = v(0, 0, 1, 0, 0, o(1, 0, `INT8, 0, 1, 0), 0);
        tbl[5]  = v(0, 0, 1, 0, 0, o(1, 0, `INT8, 0, 1, 0), 0);
        tbl[6]  = v(0, 0, 1, 0, 0, o(1, 0, `INT8, 0, 1, 0), 0);
        tbl[7]  = v(0, 0, 1, 1, 0, o(1, 0, `INT8, 0, 1, 0), 0);
        tbl[8]  = v(0, 0, 1, 0, 0, o(1, 0, `INT8, 0, 1, 0), 0);
        tbl[9]  = v(0, 0, 0, 1, 0, o(1, 0, `INT8, 0, 1, 0), 0);
        tbl[10] = v(0, 0, 0, 0, 0, o(1, 0, `INT8, 0, 1, 0), 0);
        tbl[11] = v(0, 0, 0, 0, 1, o(1, 0, `INT8, 1, 1, 0), 5);
        tbl[12] = v(0, 0, 0, 1, 0, o(1, 0, `INT8, 0, 0, 0), 0);
        tbl[13] = v(0, 0, 1, 0, 0, o(1, 0, `INT8, 0, 0, 0), 0);

        tick();
        do_reset();
        chk("reset_state", 64'({ctl(), o_rsp_id, o_rsp_tiles, o_rsp_err}), 64'({o(1, 0, 0, 0, 0, 0), 4'd0, 16'd0, 1'b0}));

        for (int i = 0; i < 14; i++) begin
            i_cmd_valid = tbl[i].vld; i_cmd_mode = tbl[i].mode; i_cmd_id = tbl[i].id;
            i_mm_tile_done = tbl[i].tile; i_mm_mtrx_done = tbl[i].mtrx; i_rsp_ready = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d_ctl", i), 64'(ctl()), 64'(tbl[i].exp_o));
            if (tbl[i].exp_o[4])
                chk($sformatf("vec%0d_rsp", i), 64'({o_rsp_id, o_rsp_tiles, o_rsp_err}),
                    64'({tbl[i].exp_id, tbl[i].exp_tiles, 1'b0}));
            tick();
        end

        // FIFO full while a job runs, then response backpressure
        do_reset();
        i_cmd_valid = 1; i_cmd_mode = `INT4; i_cmd_id = 1;
        tick();
        i_cmd_valid = 0;
        tick();
        chk("full_job_start", 64'(o_mm_start), 64'(1));
        tick();
        for (int k = 0; k < 5; k++) begin
            i_cmd_valid = 1; i_cmd_mode = `INT4_VSQ; i_cmd_id = 4'(k + 2);
            #1;
            chk($sformatf("full_push%0d", k), 64'({o_cmd_ready, o_fifo_cnt}), 64'({k < 4, 3'(k)}));
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            chk("full_hold", 64'({o_cmd_ready, o_fifo_cnt}), 64'({1'b0, 3'd4}));
            tick();
        end
        i_mm_mtrx_done = 1;
        tick();
        i_mm_mtrx_done = 0;
        for (int k = 0; k < `AD; k++) tick();
        for (int k = 0; k < 10; k++) begin
            chk("bp_hold", 64'({o_rsp_valid, o_mm_start, o_rsp_id, o_rsp_tiles, o_rsp_err}),
                64'({1'b1, 1'b0, 4'd1, 16'd0, 1'b0}));
            tick();
        end
        i_rsp_ready = 1;
        tick();
        i_rsp_ready = 0;
        chk("bp_idle", 64'(ctl()), 64'(o(0, 0, `INT4, 0, 0, 4)));
        tick();
        chk("bp_restart", 64'({ctl(), o_rsp_id}), 64'({o(1, 1, `INT4_VSQ, 0, 1, 3), 4'd2}));
        tick();
        i_cmd_valid = 0;
        chk("fifth_accepted", 64'(ctl()), 64'(o(0, 0, `INT4_VSQ, 0, 1, 4)));

        // reset during DRAIN discards the job and the queued commands
        i_mm_mtrx_done = 1;
        tick();
        i_mm_mtrx_done = 0;
        tick();
        i_rst = 1;
        tick();
        i_rst = 0;
        chk("midrst_state", 64'(ctl()), 64'(o(1, 0, 0, 0, 0, 0)));
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("midrst_quiet", 64'({o_rsp_valid, o_mm_start, o_busy}), 64'(0));
        end

`ifdef MM_SCHED_TIMEOUT_EN
        do_reset();
        i_cmd_valid = 1; i_cmd_mode = `INT8; i_cmd_id = 7;
        tick();
        i_cmd_valid = 0;
        tick();
        chk("wd_start", 64'(o_mm_start), 64'(1));
        n = 0;
        while (n < 40 && !o_rsp_valid) begin
            tick();
            n++;
        end
        chk("wd_run_cycles", 64'(n - 1), 64'(TO));
        chk("wd_rsp", 64'({o_rsp_valid, o_rsp_err, o_rsp_tiles, o_rsp_id}), 64'({1'b1, 1'b1, 16'd0, 4'd7}));
        i_rsp_ready = 1;
        tick();
        i_rsp_ready = 0;
`endif

        // randomized run against the reference model
        do_reset();
        q.delete(); ph = 0; cur = 0; mt = 0; me = 0; dl = 0; quiet = 0;
        for (int c = 0; c < 4000; c++) begin
            i_rst = $urandom_range(399) == 0;
            i_cmd_valid = 1'($urandom_range(1));
            i_cmd_mode = 2'($urandom);
            i_cmd_id = 4'($urandom);
            i_mm_tile_done = $urandom_range(2) == 0;
            i_mm_mtrx_done = $urandom_range(11) == 0;
            i_rsp_ready = 1'($urandom_range(1));
            #1;
            chk("rand_ctl", 64'(ctl()), 64'({q.size() < DEPTH, ph == 1, cur[5:4], ph == 4, ph != 0, 3'(q.size())}));
            if (ph == 4)
                chk("rand_rsp", 64'({o_rsp_id, o_rsp_tiles, o_rsp_err}), 64'({cur[3:0], mt, me}));
            if (i_rst) begin
                q.delete(); ph = 0; cur = 0; mt = 0; me = 0;
            end else begin
                push = i_cmd_valid && q.size() < DEPTH;
                case (ph)
                    0: if (q.size() != 0) begin cur = q.pop_front(); mt = 0; me = 0; ph = 1; end
                    1: begin ph = 2; quiet = 0; end
                    2: begin
                        if (i_mm_tile_done) mt = (mt == 16'hFFFF) ? mt : mt + 16'd1;
                        if (i_mm_mtrx_done) begin ph = 3; dl = `AD; end
                        else if (i_mm_tile_done) quiet = 0;
                        else begin
                            quiet++;
                            if (WD_ON && quiet == TO) begin ph = 4; me = 1; end
                        end
                    end
                    3: begin dl--; if (dl == 0) ph = 4; end
                    default: if (i_rsp_ready) ph = 0;
                endcase
                if (push) q.push_back({i_cmd_mode, i_cmd_id});
            end
            tick();
        end
        i_rst = 0;
        quiet_inputs();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
